hilbert_fir_seq: RTL and testbench

- Sequencer and multiply-accumulate engine that drives the 32-entry complex Hilbert coefficient ROM as its initiator.
- Accepts one real sample per transaction into a 32-deep delay line.
- Walks ROM addresses 0..31, multiplies each coefficient by the aligned delayed sample and accumulates real and imaginary sums.
- Presents one scaled, saturated complex output per input sample; sits between the sample source and downstream analytic-signal logic.

---
 rtl/hilbert_pkg.sv | 30 +++
 rtl/hilbert_fir_seq_if.sv | 28 ++
 rtl/hilbert_delay_line.sv | 30 +++
 rtl/hilbert_fir_seq.sv | 105 ++++++++++
 tb/tb_hilbert_fir_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/hilbert_pkg.sv
// Shared constants, FSM state type and output scaling for the Hilbert FIR sequencer.
// All widths derive from the tap count and the Q8.24 coefficient format.
package hilbert_pkg;

    localparam int TAPS      = 32;
    localparam int ADDR_W    = $clog2(TAPS);
    localparam int DIN_W     = 16;
    localparam int COEF_W    = 32;
    localparam int COEF_FRAC = 24;
    localparam int OUT_W     = 16;
    localparam int PROD_W    = DIN_W + COEF_W;
    localparam int ACC_W     = DIN_W + COEF_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        DONE
    } state_t;

    // Floor-shift away the coefficient fraction, then clamp into the output range.
    function automatic logic signed [OUT_W-1:0] shift_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> COEF_FRAC;
        if (sh[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){sh[ACC_W-1]}})
            return sh[OUT_W-1:0];
        return sh[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/hilbert_fir_seq_if.sv
// Sample-in, coefficient-ROM and result-out signals of the Hilbert FIR sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface hilbert_fir_seq_if
    import hilbert_pkg::*;
();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DIN_W-1:0]  in_data;
    logic [ADDR_W-1:0]        rom_addr;
    logic signed [COEF_W-1:0] rom_data_re;
    logic signed [COEF_W-1:0] rom_data_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_re;
    logic signed [OUT_W-1:0]  out_im;

    modport slave (
        input  in_valid, in_data, rom_data_re, rom_data_im, out_ready,
        output in_ready, rom_addr, out_valid, out_re, out_im
    );

    modport master (
        output in_valid, in_data, rom_data_re, rom_data_im, out_ready,
        input  in_ready, rom_addr, out_valid, out_re, out_im
    );

endinterface

// File: rtl/hilbert_delay_line.sv
// Circular sample buffer: a write advances the head and stores at the new head;
// the read port returns the sample k positions older than the head.
module hilbert_delay_line
    import hilbert_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic signed [DIN_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]       rd_k,
    output logic signed [DIN_W-1:0] rd_data
);

    logic signed [DIN_W-1:0] mem [TAPS];
    logic [ADDR_W-1:0]       head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            for (int i = 0; i < TAPS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            head                    <= head + ADDR_W'(1);
            mem[head + ADDR_W'(1)]  <= wr_data;
        end
    end

    // Index arithmetic wraps naturally because TAPS is a power of two.
    assign rd_data = mem[head - rd_k];

endmodule

// File: rtl/hilbert_fir_seq.sv
// Hilbert FIR sequencer: per accepted sample, walks the coefficient ROM over the
// delay line, accumulates complex products and presents one saturated complex result.
module hilbert_fir_seq
    import hilbert_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    hilbert_fir_seq_if.slave bus
);

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        k;
    logic signed [DIN_W-1:0]  x;
    logic                     vld_p1;
    logic signed [PROD_W-1:0] prod_re_p1, prod_im_p1;
    logic signed [ACC_W-1:0]  acc_re_p2, acc_im_p2;
    logic signed [ACC_W-1:0]  sum_re, sum_im;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_re_q, out_im_q;
    logic                     accept;

    assign accept = (state == IDLE) && bus.in_valid;

    hilbert_delay_line u_delay (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (bus.in_data),
        .rd_k    (k),
        .rd_data (x)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = MAC;
            MAC:     if (k == ADDR_W'(TAPS - 1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sum_re = acc_re_p2 + ACC_W'(prod_re_p1);
    assign sum_im = acc_im_p2 + ACC_W'(prod_im_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k           <= '0;
            vld_p1      <= 1'b0;
            prod_re_p1  <= '0;
            prod_im_p1  <= '0;
            acc_re_p2   <= '0;
            acc_im_p2   <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            vld_p1 <= (state == MAC);
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        k         <= '0;
                        acc_re_p2 <= '0;
                        acc_im_p2 <= '0;
                    end
                end
                // Stage p1: product of tap k; stage p2: accumulate the previous tap.
                MAC: begin
                    k          <= k + ADDR_W'(1);
                    prod_re_p1 <= PROD_W'(x) * PROD_W'(bus.rom_data_re);
                    prod_im_p1 <= PROD_W'(x) * PROD_W'(bus.rom_data_im);
                    if (vld_p1) begin
                        acc_re_p2 <= sum_re;
                        acc_im_p2 <= sum_im;
                    end
                end
                // Last tap folds in here and the result is registered in the same edge.
                DRAIN: begin
                    acc_re_p2   <= sum_re;
                    acc_im_p2   <= sum_im;
                    out_re_q    <= shift_sat(sum_re);
                    out_im_q    <= shift_sat(sum_im);
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.rom_addr  = (state == MAC) ? k : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;

endmodule

// File: tb/tb_hilbert_fir_seq.sv
// Directed and randomized bench for hilbert_fir_seq with a bench-side coefficient ROM
// and a convolution reference model over the most recent TAPS samples.
module tb_hilbert_fir_seq;
    import hilbert_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   ntests;
    int   nfail;

    logic signed [COEF_W-1:0] c_re [TAPS];
    logic signed [COEF_W-1:0] c_im [TAPS];
    int   hist[$];
    int   prev_acc;
    bit   chk_spacing;
    bit   hold_valid;

    hilbert_fir_seq_if bus ();

    hilbert_fir_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_data_re = c_re[bus.rom_addr];
    assign bus.rom_data_im = c_im[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Direct convolution of the newest TAPS samples with the coefficients, floor-scaled and clamped.
    function automatic logic signed [15:0] model(input bit im);
        longint acc;
        acc = 0;
        for (int t = 0; t < TAPS; t++)
            acc += longint'(hist[t]) * longint'(im ? c_im[t] : c_re[t]);
        acc = acc >>> COEF_FRAC;
        if (acc > 32767)  return 16'sh7FFF;
        if (acc < -32768) return 16'sh8000;
        return 16'(acc);
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int t = 0; t < TAPS; t++) hist.push_back(0);
    endtask

    function automatic logic signed [COEF_W-1:0] rand_coef();
        int mag;
        mag = int'($urandom_range(4194304, 2097152));
        return ($urandom_range(1, 0) == 1) ? COEF_W'(-mag) : COEF_W'(mag);
    endfunction

    task automatic xfer(input logic signed [15:0] s, input int hold, output logic signed [15:0] got_re);
        int n;
        int bad;
        int acc_cyc;
        logic signed [15:0] exp_re, exp_im, held_re, held_im;
        bus.in_data   = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("accept_wait", bus.in_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (hold_valid) bus.in_data = s ^ 16'sh5555;
        else            bus.in_valid = 1'b0;
        hist.push_front(int'(s));
        void'(hist.pop_back());
        exp_re = model(1'b0);
        exp_im = model(1'b1);
        if (chk_spacing && prev_acc >= 0) check("accept_spacing", acc_cyc - prev_acc, TAPS + 3);
        prev_acc = (hold == 0) ? acc_cyc : -1;

        n = 0; bad = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            if (n < TAPS) begin
                if (bus.rom_addr !== ADDR_W'(n)) bad++;
            end else if (bus.rom_addr !== '0) bad++;
            @(posedge clk); #1; n++;
        end
        check("rom_addr_seq", bad, 0);
        // Counting the accepting edge as the first, OUT_VALID rises on the 34th edge.
        check("latency", n + 1, 34);
        check("out_re", bus.out_re, exp_re);
        check("out_im", bus.out_im, exp_im);
        got_re = bus.out_re;

        held_re = bus.out_re; held_im = bus.out_im; bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.out_re !== held_re ||
                bus.out_im !== held_im || bus.in_ready !== 1'b0) bad++;
        end
        if (hold > 0) check("backpressure_hold", bad, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", bus.out_valid, 0);
        check("in_ready_back", bus.in_ready, 1);
    endtask

    initial begin
        logic signed [15:0] r;
        logic signed [15:0] s;
        ntests = 0; nfail = 0; cyc = 0; prev_acc = -1;
        chk_spacing = 1'b0; hold_valid = 1'b0;
        c_re[0] = '0;
        c_re[1] = 32'hFFE4CC88;
        c_re[2] = 32'h002DA5B3;
        for (int i = 3; i < TAPS; i++) c_re[i] = rand_coef();
        for (int i = 0; i < TAPS; i++) c_im[i] = '0;
        model_clear();

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_re", bus.out_re, 0);
        check("rst_out_im", bus.out_im, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        @(posedge clk); #1;

        // Impulse response with IN_VALID held high throughout.
        chk_spacing = 1'b1; hold_valid = 1'b1;
        for (int n = 0; n < TAPS; n++) begin
            xfer((n == 0) ? 16'sh4000 : 16'sh0000, 0, r);
            if (n == 0) check("impulse_y0", r, 0);
            if (n == 1) check("impulse_y1", r, -1741);
            if (n == 2) check("impulse_y2", r, 2921);
        end
        chk_spacing = 1'b0;

        // Imaginary coefficients become live from here on.
        for (int i = 0; i < TAPS; i++) c_im[i] = rand_coef();

        xfer(16'sh0123, 10, r);
        xfer(-16'sh0456, 10, r);
        hold_valid = 1'b0;

        for (int j = 0; j < TAPS; j++) begin
            s = (c_re[TAPS-1-j] < 0) ? -16'sd32767 : 16'sd32767;
            xfer(s, 0, r);
        end
        check("sat_pos", r, 16'sh7FFF);
        for (int j = 0; j < TAPS; j++) begin
            s = (c_re[TAPS-1-j] < 0) ? 16'sd32767 : -16'sd32767;
            xfer(s, 0, r);
        end
        check("sat_neg", r, 16'sh8000);

        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(3, 0) == 0) s = 16'($urandom);
            else                           s = 16'($urandom_range(200, 0)) - 16'sd100;
            xfer(s, (j % 7 == 3) ? 2 : 0, r);
        end

        // Reset in the middle of a MAC pass.
        bus.in_data = 16'sh3000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_mac_addr", bus.rom_addr, 10);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_rom_addr", bus.rom_addr, 0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        model_clear();
        xfer(16'sh4000, 0, r);
        check("post_rst_y0", r, 0);
        xfer(16'sh0000, 0, r);
        check("post_rst_y1", r, -1741);
        xfer(16'sh0000, 0, r);
        check("post_rst_y2", r, 2921);

        // Reset while a result is pending downstream.
        bus.in_data = 16'sh1111; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 100 && bus.out_valid !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        check("done_reached", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("done_rst_out_valid", bus.out_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (bus.out_valid !== 1'b0) seen++;
            end
            check("done_rst_discard", seen, 0);
        end
        model_clear();
        xfer(16'sh0777, 0, r);
        xfer(-16'sh0100, 0, r);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
